fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width per requester.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 Parameter MAX_BURST, default 4, max accepted beats per grant (>=1).
REQ-004 Localparam ID_BITS = max(1, clog2(NUM_REQ)); OUT_W = DATA_WIDTH, or DATA_WIDTH+ID_BITS with FIFO_ARB_TAG_EN.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  bit i = requester i has a beat.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  requester i payload in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  out  NUM_REQ  bit i = requester i beat accepted this cycle.
REQ-010 fifo_full  in  1  full flag of downstream FIFO.
REQ-011 fifo_wr_en  out  1  write strobe to FIFO.
REQ-012 fifo_din  out  OUT_W  write data to FIFO.
REQ-013 grant_id  out  ID_BITS  index of current grant holder (registered).
REQ-014 busy  out  1  high while in GRANT.

Function
REQ-015 FSM states IDLE and GRANT; registers state, grant_id, last_grant, burst_cnt (width clog2(MAX_BURST)+1).
REQ-016 Round-robin: winner = first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-017 IDLE: any req_valid -> GRANT next cycle, grant_id=last_grant=winner, burst_cnt=0; none -> stay IDLE; one-cycle arbitration latency.
REQ-018 Beat accepted in a cycle iff state=GRANT, req_valid[grant_id]=1, fifo_full=0.
REQ-019 fifo_wr_en and req_ready[grant_id] combinationally equal the accept condition; all other req_ready bits 0; no write in IDLE.
REQ-020 fifo_din[DATA_WIDTH-1:0] = req_data slice of grant_id, combinational; value don't-care when fifo_wr_en=0.
REQ-021 Accepted beat increments burst_cnt.
REQ-022 Release when accepted beat brings burst_cnt to MAX_BURST, or req_valid[grant_id]=0 in GRANT.
REQ-023 On release: any req_valid (including releasing requester) -> remain GRANT with new round-robin winner from REQ-016 (evaluated with last_grant = outgoing grant), burst_cnt=0; else -> IDLE.
REQ-024 fifo_full=1 with req_valid[grant_id]=1: hold grant, no accept, burst_cnt unchanged, no release (stall indefinitely).
REQ-025 MAX_BURST=1: release after every accepted beat.
REQ-026 Never more than one fifo_wr_en per cycle; never writes while fifo_full=1.

Reset
REQ-027 rst_=1 at rising edge: state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), burst_cnt=0.
REQ-028 While rst_=1: fifo_wr_en=0, req_ready=0, busy=0, combinationally, regardless of state.
REQ-029 Reset mid-burst: in-flight grant abandoned, no beat accepted in reset cycle; arbitration restarts from REQ-027 values.

Configuration
REQ-030 Macro FIFO_ARB_TAG_EN defined: fifo_din is DATA_WIDTH+ID_BITS wide, fifo_din[OUT_W-1:DATA_WIDTH] = grant_id on every write.
REQ-031 Macro FIFO_ARB_TAG_EN undefined: fifo_din is DATA_WIDTH wide, no tag logic; all other behaviour identical.

Verification (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8)
REQ-032 Reset, then req_valid=4'b1111 held, fifo_full=0 -> grants 0,1,2,3,0 in order, 4 writes each, no gaps between grants after first IDLE cycle.
REQ-033 Only req 2 valid, sends 2 beats (0xA1,0xA2) then drops valid -> 2 writes 0xA1,0xA2, release, state IDLE next cycle, last_grant=2.
REQ-034 Req 1 granted, fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 those cycles, grant_id stays 1, burst resumes with remaining beats.
REQ-035 Req 0 bursting, rst_=1 after 2 beats -> no write in reset cycle, after reset req_valid=4'b0011 -> requester 0 granted first.
REQ-036 FIFO_ARB_TAG_EN defined, req 3 writes 0x5C -> fifo_din=10'b11_0101_1100; undefined -> fifo_din=8'h5C.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that funnels NUM_REQ valid/ready requesters into the
// write port of one downstream FIFO. The winner keeps the grant for up to
// MAX_BURST accepted beats. The grant is released early when the holder
// drops valid. A full FIFO stalls the holder without releasing it.
//
// Optional build macro: FIFO_ARB_TAG_EN. When it is defined, fifo_din also
// carries grant_id above the payload bits.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_        in   synchronous active-high reset
//   req_valid   in   [NUM_REQ]             requester i has a beat
//   req_data    in   [NUM_REQ*DATA_WIDTH]  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   out  [NUM_REQ]             requester i beat accepted this cycle
//   fifo_full   in   downstream FIFO full flag
//   fifo_wr_en  out  FIFO write strobe
//   fifo_din    out  [OUT_W]               FIFO write data (tag above payload when enabled)
//   grant_id    out  [ID_BITS]             registered index of grant holder
//   busy        out  high while in GRANT
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant; any valid request wins arbitration for next cycle
// ST_GRANT| grant_id owns the FIFO write port until burst end or drop
module fifo_wr_arbiter #(
   parameter  int DATA_WIDTH = 8,
   parameter  int NUM_REQ    = 4,
   parameter  int MAX_BURST  = 4,
   localparam int ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
`ifdef FIFO_ARB_TAG_EN
   localparam int OUT_W      = DATA_WIDTH + ID_BITS,
`else
   localparam int OUT_W      = DATA_WIDTH,
`endif
   localparam int CNT_W      = $clog2(MAX_BURST) + 1
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [OUT_W-1:0]              fifo_din,
   output logic [ID_BITS-1:0]            grant_id,
   output logic                          busy
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t               r_state, w_state_nxt;
   logic [ID_BITS-1:0]   r_grant_id, w_grant_nxt;
   logic [ID_BITS-1:0]   r_last_grant, w_last_nxt;
   logic [CNT_W-1:0]     r_burst_cnt, w_cnt_nxt;

   logic [ID_BITS-1:0]   w_winner;
   logic [ID_BITS-1:0]   w_idx;
   logic                 w_found;
   logic                 w_any;
   logic                 w_cur_valid;
   logic                 w_accept;
   logic                 w_last_beat;
   logic                 w_release;
   logic [DATA_WIDTH-1:0] w_data;

   assign w_any       = |req_valid;
   assign w_cur_valid = req_valid[r_grant_id];

   // Search starts one past the last grant and wraps. In GRANT,
   // last_grant equals grant_id, so the same search serves a release.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_BITS'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_winner = w_idx;
            w_found  = 1'b1;
         end
      end
   end

   assign w_accept    = !rst_ && (r_state == ST_GRANT) && w_cur_valid && !fifo_full;
   assign w_last_beat = (int'(r_burst_cnt) + 1) == MAX_BURST;
   // A stalled holder (valid high, FIFO full) matches neither release term.
   assign w_release   = (r_state == ST_GRANT) && ((w_accept && w_last_beat) || !w_cur_valid);

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_id;
      w_last_nxt  = r_last_grant;
      w_cnt_nxt   = r_burst_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_GRANT;
               w_grant_nxt = w_winner;
               w_last_nxt  = w_winner;
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_cnt_nxt = '0;
               if (w_any) begin
                  w_grant_nxt = w_winner;
                  w_last_nxt  = w_winner;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_accept) begin
               w_cnt_nxt = r_burst_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= ID_BITS'(NUM_REQ - 1);
         r_burst_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_id   <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         r_burst_cnt  <= w_cnt_nxt;
      end
   end

   assign w_data     = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_wr_en = w_accept;
   assign req_ready  = w_accept ? (NUM_REQ'(1) << r_grant_id) : '0;
   assign busy       = !rst_ && (r_state == ST_GRANT);
   assign grant_id   = r_grant_id;

`ifdef FIFO_ARB_TAG_EN
   assign fifo_din   = {r_grant_id, w_data};
`else
   assign fifo_din   = w_data;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter with NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8.
// Part 1 is a per-cycle vector table that covers reset, a FIFO-full stall
// and a reset in the middle of a burst.
// Part 2 uses a requester model with a queue of expected writes. It covers
// round-robin bursts, an early drop of valid, and the tag option.
module tb_fifo_wr_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
`ifdef FIFO_ARB_TAG_EN
   localparam int OW = DW + 2;
`else
   localparam int OW = DW;
`endif

   logic           clk = 1'b0;
   logic           rst_;
   logic [NR-1:0]  req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]  req_ready;
   logic           fifo_full;
   logic           fifo_wr_en;
   logic [OW-1:0]  fifo_din;
   logic [1:0]     grant_id;
   logic           busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
      .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      logic       full;
      logic       wr;
      logic [3:0] rdy;
      logic       bsy;
      logic [1:0] gid;
   } vec_t;
   vec_t tbl[21];

   int         left[NR];
   logic [7:0] base[NR];
   logic [7:0] cnt[NR];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [OW-1:0] mk_din(input logic [1:0] id, input logic [7:0] d);
      logic [9:0] full_w;
      full_w = {id, d};
      return OW'(full_w);
   endfunction

   task automatic drive_model();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = (left[i] != 0);
         req_data[i*DW +: DW] = base[i] + cnt[i];
      end
   endtask

   // One cycle: drive at negedge, check 1 ns later, then update the model.
   task automatic step(input string tag, input logic rst, input logic full, output logic wr);
      exp_t e;
      @(negedge clk);
      rst_      = rst;
      fifo_full = full;
      drive_model();
      #1;
      wr = fifo_wr_en;
      if (fifo_wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_write actual=1 required=0", tag);
         end else begin
            e = sb.pop_front();
            chk({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
            chk({tag, "_fifo_din"}, 32'(fifo_din), 32'(mk_din(e.id, e.data)));
            chk({tag, "_req_ready"}, 32'(req_ready), 32'(1) << e.id);
            left[e.id] = left[e.id] - 1;
            cnt[e.id]  = cnt[e.id] + 8'd1;
         end
      end else begin
         chk({tag, "_ready_idle"}, 32'(req_ready), 32'd0);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         left[i] = 0;
         base[i] = 8'h00;
         cnt[i]  = 8'h00;
      end
   endtask

   initial begin
      logic wr;
      exp_t e;

      // row: rst valid full | wr rdy busy gid
      tbl[0]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
      tbl[1]  = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[3]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[4]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[5]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[6]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[7]  = '{1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[8]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[9]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[10] = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[11] = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
      tbl[14] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
      tbl[15] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[16] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[17] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
      tbl[18] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
      tbl[19] = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[20] = '{1'b0, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};

      clear_model();
      base[0] = 8'h11; base[1] = 8'h22; base[2] = 8'h33; base[3] = 8'h44;
      rst_ = 1'b1; fifo_full = 1'b0; req_valid = '0;
      drive_model();

      // Part 1: vector table.
      @(negedge clk);
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         rst_      = tbl[k].rst;
         req_valid = tbl[k].valid;
         fifo_full = tbl[k].full;
         #1;
         chk($sformatf("vec%0d_wr_en", k), 32'(fifo_wr_en), 32'(tbl[k].wr));
         chk($sformatf("vec%0d_req_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
         chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].bsy));
         chk($sformatf("vec%0d_grant_id", k), 32'(grant_id), 32'(tbl[k].gid));
         if (tbl[k].wr)
            chk($sformatf("vec%0d_fifo_din", k), 32'(fifo_din),
                32'(mk_din(tbl[k].gid, base[tbl[k].gid])));
      end

      // Part 2a: all requesters held valid; 5 full bursts with no gaps.
      clear_model();
      for (int i = 0; i < NR; i++) base[i] = 8'(i << 4);
      step("rr_rst", 1'b1, 1'b0, wr);
      step("rr_rst", 1'b1, 1'b0, wr);
      for (int i = 0; i < NR; i++) left[i] = 1000;
      for (int b = 0; b < 5; b++) begin
         for (int j = 0; j < 4; j++) begin
            e.id   = 2'(b % 4);
            e.data = 8'((int'(e.id) << 4) + ((b == 4) ? 4 + j : j));
            sb.push_back(e);
         end
      end
      step("rr", 1'b0, 1'b0, wr);
      chk("rr_first_idle", 32'(wr), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         step("rr", 1'b0, 1'b0, wr);
         chk($sformatf("rr_no_gap%0d", k), 32'(wr), 32'd1);
      end
      chk("rr_sb_empty", 32'(sb.size()), 32'd0);
      for (int i = 0; i < NR; i++) left[i] = 0;
      step("rr_drop", 1'b0, 1'b0, wr);
      chk("rr_drop_busy", 32'(busy), 32'd1);
      chk("rr_drop_gid", 32'(grant_id), 32'd1);
      step("rr_idle", 1'b0, 1'b0, wr);
      chk("rr_idle_busy", 32'(busy), 32'd0);

      // Part 2b: requester 2 sends two beats and drops valid.
      clear_model();
      step("s2_rst", 1'b1, 1'b0, wr);
      step("s2_rst", 1'b1, 1'b0, wr);
      base[2] = 8'hA1; left[2] = 2;
      e.id = 2'd2; e.data = 8'hA1; sb.push_back(e);
      e.id = 2'd2; e.data = 8'hA2; sb.push_back(e);
      step("s2", 1'b0, 1'b0, wr);
      chk("s2_arb_cycle", 32'(wr), 32'd0);
      step("s2", 1'b0, 1'b0, wr);
      chk("s2_beat1", 32'(wr), 32'd1);
      step("s2", 1'b0, 1'b0, wr);
      chk("s2_beat2", 32'(wr), 32'd1);
      step("s2_rel", 1'b0, 1'b0, wr);
      chk("s2_rel_wr", 32'(wr), 32'd0);
      chk("s2_rel_busy", 32'(busy), 32'd1);
      step("s2_idle", 1'b0, 1'b0, wr);
      chk("s2_idle_busy", 32'(busy), 32'd0);

      // With last grant 2, requesters 0 and 3 contend: 3 wins first.
      base[0] = 8'h07; left[0] = 1;
      base[3] = 8'h5C; cnt[3] = 8'h00; left[3] = 1;
      e.id = 2'd3; e.data = 8'h5C; sb.push_back(e);
      e.id = 2'd0; e.data = 8'h07; sb.push_back(e);
      step("p", 1'b0, 1'b0, wr);
      chk("p_arb_cycle", 32'(wr), 32'd0);
      step("p", 1'b0, 1'b0, wr);
      chk("p_req3_wr", 32'(wr), 32'd1);
`ifdef FIFO_ARB_TAG_EN
      chk("tag_din", 32'(fifo_din), 32'(10'b11_0101_1100));
`else
      chk("tag_din", 32'(fifo_din), 32'h5C);
`endif
      step("p", 1'b0, 1'b0, wr);
      chk("p_release", 32'(wr), 32'd0);
      step("p", 1'b0, 1'b0, wr);
      chk("p_req0_wr", 32'(wr), 32'd1);
      step("p", 1'b0, 1'b0, wr);
      chk("p_end_busy", 32'(busy), 32'd1);
      step("p", 1'b0, 1'b0, wr);
      chk("p_idle_busy", 32'(busy), 32'd0);
      chk("p_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
